z80_stack_pop_seq: RTL and testbench
====================================

# z80_stack_pop_seq

Sequences the stack-pop family (RET, RET cc, POP qq) for the core. Latches SP, PC, F and the decoded condition from the decoder on a start strobe, then evaluates the condition. When the pop is taken, it issues two byte reads on the memory-read port (SP, then SP+1). It finishes with a one-cycle completion strobe carrying the new SP, new IP and popped word, which the register file commits.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request strobe; accepted only when busy=0
- op  in  2  0=RET, 1=RET cc, 2=POP qq, 3=reserved
- cond  in  3  condition field (insn[5:3]), used only for op=1
- f_in  in  8  flag register (S=7, Z=6, PV=2, C=0)
- sp_in  in  16  stack pointer at start
- ip_in  in  16  address of the instruction's opcode byte
- mem_rd  out  1  read request
- mem_addr  out  16  read address
- mem_rdata  in  8  read data, valid when mem_rd && mem_ack
- mem_ack  in  1  read completes on an edge where mem_rd && mem_ack
- busy  out  1  high from accept through the done cycle
- done  out  1  one-cycle completion strobe
- taken  out  1  valid with done: stack was popped
- sp_out  out  16  new SP, valid with done
- ip_out  out  16  new IP, valid with done
- pop_data  out  16  {high byte, low byte}, valid with done
- sp_we, ip_we, qq_we  out  1 each  register-write enables, asserted only during done

## Operation
- States: IDLE, COND, RD_LO, RD_HI, DONE. Reset and IDLE both drive every output to 0.
- IDLE: on start=1, latch op, cond, f_in, sp_in and ip_in, then go to COND. Inputs are ignored at all other times.
- COND: cond_met = 1 for op 0 and 2, and 0 for op 3.
  - For op=1, cond selects the flag: 0/1→Z, 2/3→C, 4/5→PV, 6/7→S.
  - cond_met = (flag == cond[0]).
  - cond_met=1 → RD_LO. Otherwise → DONE with taken=0.
- RD_LO: mem_rd=1, mem_addr=SP. On ack, capture the low byte and go to RD_HI.
- RD_HI: mem_rd=1, mem_addr=SP+1 (mod 2^16). On ack, capture the high byte and go to DONE with taken=1.
- DONE: done=1 for one cycle, then → IDLE.
  - taken=0: sp_out=SP, ip_out=IP+1, pop_data=0, sp_we=0, ip_we=1, qq_we=0.
  - taken=1, op 0/1: sp_out=SP+2, ip_out={hi,lo}, sp_we=1, ip_we=1, qq_we=0.
  - taken=1, op 2: sp_out=SP+2, ip_out=IP+1, pop_data={hi,lo}, sp_we=1, ip_we=1, qq_we=1.
- Address arithmetic is 16-bit and wraps silently. SP=FFFF reads FFFF then 0000 and gives sp_out=0001. IP=FFFF gives ip_out=0000.
- mem_ack is ignored when mem_rd=0. mem_rdata is sampled only on the acknowledged edge.
- start during busy is dropped; there is no queueing. start in the DONE cycle is also dropped.
- Reset asserted mid-operation forces IDLE immediately and deasserts mem_rd asynchronously. No done is produced for the aborted pop.

## Timing
- start is sampled at edge E0. COND occupies the cycle after E0, and busy=1 from E0.
- Not taken: done is high in the 2nd cycle after E0.
- Taken, zero wait states: RD_LO in cycle 2, RD_HI in cycle 3, done in cycle 4.
- Each cycle with mem_rd=1 and mem_ack=0 adds one cycle. mem_addr and mem_rd stay stable until acked.
- Outputs are registered; none is combinationally dependent on start. done→IDLE takes one cycle, so back-to-back pops are spaced 1 idle cycle apart.

## Test plan
- RET, SP=1234, mem[1234]=CD, mem[1235]=AB, zero waits → done at cycle 4, taken=1, ip_out=ABCD, sp_out=1236, sp_we=ip_we=1, qq_we=0.
- RET NZ (op=1, cond=0), f_in=40 (Z=1) → no mem_rd ever, done at cycle 2, taken=0, ip_out=ip_in+1, sp_out=sp_in, sp_we=0.
  - Sweep all 8 cond values against F=00 and F=C5: taken must equal flag==cond[0].
- POP, SP=FFFF, mem[FFFF]=11, mem[0000]=22 → mem_addr FFFF then 0000, pop_data=2211, sp_out=0001, ip_out=ip_in+1, qq_we=1.
- RET with mem_ack low for 3 cycles on each byte → mem_addr held stable, done at cycle 10. start pulses while busy are ignored, and ack pulses while mem_rd=0 have no effect.
- Drop reset_n during RD_HI → mem_rd=0 and all outputs 0 immediately, no done. A start after reset release runs a full, correct pop.

Source files
------------

// File: rtl/z80_stack_pop_seq.sv
// Z80 stack-pop sequencer for RET, RET cc and POP qq.
// Ports: start/op/cond/f_in/sp_in/ip_in in; mem_rd/mem_addr/mem_rdata/mem_ack; done bundle out.
module z80_stack_pop_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [2:0]  cond,
  input  logic [7:0]  f_in,
  input  logic [15:0] sp_in,
  input  logic [15:0] ip_in,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        taken,
  output logic [15:0] sp_out,
  output logic [15:0] ip_out,
  output logic [15:0] pop_data,
  output logic        sp_we,
  output logic        ip_we,
  output logic        qq_we
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COND,
    S_RD_LO,
    S_RD_HI,
    S_DONE
  } state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [2:0]  cond_q;
  logic [7:0]  f_q;
  logic [15:0] sp_q;
  logic [15:0] ip_q;
  logic [7:0]  lo_q;

  logic        flag;
  logic        cond_met;
  logic [15:0] sp_p1;
  logic [15:0] sp_p2;
  logic [15:0] ip_p1;
  logic [15:0] word;

  assign sp_p1 = sp_q + 16'd1;
  assign sp_p2 = sp_q + 16'd2;
  assign ip_p1 = ip_q + 16'd1;
  assign word  = {mem_rdata, lo_q};

  // cond[2:1] picks the flag, cond[0] is the polarity it must match.
  always_comb begin
    flag = 1'b0;
    unique case (cond_q[2:1])
      2'd0: flag = f_q[6];
      2'd1: flag = f_q[0];
      2'd2: flag = f_q[2];
      2'd3: flag = f_q[7];
      default: flag = 1'b0;
    endcase
    cond_met = 1'b0;
    unique case (op_q)
      2'd0: cond_met = 1'b1;
      2'd1: cond_met = (flag == cond_q[0]);
      2'd2: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      op_q     <= 2'd0;
      cond_q   <= 3'd0;
      f_q      <= 8'd0;
      sp_q     <= 16'd0;
      ip_q     <= 16'd0;
      lo_q     <= 8'd0;
      mem_rd   <= 1'b0;
      mem_addr <= 16'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      taken    <= 1'b0;
      sp_out   <= 16'd0;
      ip_out   <= 16'd0;
      pop_data <= 16'd0;
      sp_we    <= 1'b0;
      ip_we    <= 1'b0;
      qq_we    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_q   <= op;
            cond_q <= cond;
            f_q    <= f_in;
            sp_q   <= sp_in;
            ip_q   <= ip_in;
            busy   <= 1'b1;
            state  <= S_COND;
          end
        end
        S_COND: begin
          if (cond_met) begin
            mem_rd   <= 1'b1;
            mem_addr <= sp_q;
            state    <= S_RD_LO;
          end else begin
            done     <= 1'b1;
            taken    <= 1'b0;
            sp_out   <= sp_q;
            ip_out   <= ip_p1;
            pop_data <= 16'd0;
            ip_we    <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_RD_LO: begin
          if (mem_ack) begin
            lo_q     <= mem_rdata;
            mem_addr <= sp_p1;
            state    <= S_RD_HI;
          end
        end
        S_RD_HI: begin
          if (mem_ack) begin
            mem_rd   <= 1'b0;
            mem_addr <= 16'd0;
            done     <= 1'b1;
            taken    <= 1'b1;
            sp_out   <= sp_p2;
            pop_data <= word;
            sp_we    <= 1'b1;
            ip_we    <= 1'b1;
            if (op_q == 2'd2) begin
              ip_out <= ip_p1;
              qq_we  <= 1'b1;
            end else begin
              ip_out <= word;
            end
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          busy     <= 1'b0;
          done     <= 1'b0;
          taken    <= 1'b0;
          sp_out   <= 16'd0;
          ip_out   <= 16'd0;
          pop_data <= 16'd0;
          sp_we    <= 1'b0;
          ip_we    <= 1'b0;
          qq_we    <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_stack_pop_seq.sv
// Scoreboard bench for z80_stack_pop_seq.
// Memory model with wait states, stray acks/starts, reset abort.
module tb_z80_stack_pop_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [2:0]  cond;
  logic [7:0]  f_in;
  logic [15:0] sp_in;
  logic [15:0] ip_in;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic        taken;
  logic [15:0] sp_out;
  logic [15:0] ip_out;
  logic [15:0] pop_data;
  logic        sp_we;
  logic        ip_we;
  logic        qq_we;

  z80_stack_pop_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .cond(cond), .f_in(f_in), .sp_in(sp_in), .ip_in(ip_in),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy), .done(done), .taken(taken),
    .sp_out(sp_out), .ip_out(ip_out), .pop_data(pop_data),
    .sp_we(sp_we), .ip_we(ip_we), .qq_we(qq_we)
  );

  typedef struct {
    int          dcyc;
    logic        tk;
    logic [15:0] sp;
    logic [15:0] ip;
    logic [15:0] pd;
    logic        chk_pd;
    logic        sw;
    logic        iw;
    logic        qw;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] aq[$];
  logic [7:0]  mem [65536];
  int          n_chk;
  int          n_pass;
  int          cyc;
  int          ndone;
  int          waits;
  int          wcnt;
  bit          stray;
  exp_t        me;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s got %h want %h", tag, obs, exp);
  endtask

  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (done) begin
      ndone++;
      if (sb.size() == 0) begin
        chk("done_unexp", 1, 0);
      end else begin
        me = sb.pop_front();
        chk("lat", cyc, me.dcyc);
        chk("taken", {31'd0, taken}, {31'd0, me.tk});
        chk("sp_out", {16'd0, sp_out}, {16'd0, me.sp});
        chk("ip_out", {16'd0, ip_out}, {16'd0, me.ip});
        if (me.chk_pd)
          chk("pop_data", {16'd0, pop_data}, {16'd0, me.pd});
        chk("we", {29'd0, sp_we, ip_we, qq_we},
            {29'd0, me.sw, me.iw, me.qw});
        chk("busy_done", {31'd0, busy}, 1);
        chk("rd_done", {31'd0, mem_rd}, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (mem_rd) begin
      if (aq.size() == 0) begin
        chk("rd_unexp", 1, 0);
        mem_ack = 1'b1;
      end else begin
        chk("addr", {16'd0, mem_addr}, {16'd0, aq[0]});
        if (wcnt == waits) begin
          mem_ack = 1'b1;
          wcnt = 0;
          void'(aq.pop_front());
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end
    end else begin
      mem_ack = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      wcnt = 0;
    end
  end

  function automatic bit model_met(input logic [1:0] o,
                                   input logic [2:0] c,
                                   input logic [7:0] f);
    logic fl;
    case (c[2:1])
      2'd0: fl = f[6];
      2'd1: fl = f[0];
      2'd2: fl = f[2];
      default: fl = f[7];
    endcase
    if (o == 2'd0 || o == 2'd2) return 1'b1;
    if (o == 2'd1) return fl == c[0];
    return 1'b0;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [2:0] c,
                        input logic [7:0] f, input logic [15:0] s,
                        input logic [15:0] i, input int w,
                        input bit noise);
    exp_t        e;
    bit          met;
    logic [15:0] s1;
    logic [15:0] wd;
    int          n0;
    met = model_met(o, c, f);
    s1 = s + 16'd1;
    wd = {mem[s1], mem[s]};
    e.tk = met;
    e.sp = met ? s + 16'd2 : s;
    e.ip = (met && o != 2'd2) ? wd : i + 16'd1;
    e.pd = met ? wd : 16'd0;
    e.chk_pd = !met || o == 2'd2;
    e.sw = met;
    e.iw = 1'b1;
    e.qw = met && o == 2'd2;
    waits = w;
    stray = noise;
    if (met) begin
      aq.push_back(s);
      aq.push_back(s1);
    end
    @(negedge clk);
    op = o; cond = c; f_in = f; sp_in = s; ip_in = i;
    start = 1'b1;
    e.dcyc = cyc + (met ? 4 + 2 * w : 2);
    sb.push_back(e);
    n0 = ndone;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (ndone != n0) break;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        op = 2'($urandom_range(0, 2));
        sp_in = 16'($urandom);
        ip_in = 16'($urandom);
      end
    end
    start = 1'b0;
    stray = 1'b0;
    if (ndone == n0) chk("timeout", 0, 1);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; ndone = 0;
    waits = 0; wcnt = 0; stray = 1'b0;
    reset_n = 1'b0; start = 1'b0; op = 2'd0; cond = 3'd0;
    f_in = 8'd0; sp_in = 16'd0; ip_in = 16'd0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a ^ (a >> 8));
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_outs", {mem_rd, done, taken, sp_we, ip_we, qq_we,
                     mem_addr, sp_out | ip_out | pop_data}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    mem[16'h1234] = 8'hCD; mem[16'h1235] = 8'hAB;
    run_op(2'd0, 3'd0, 8'h00, 16'h1234, 16'h0100, 0, 1'b0);
    run_op(2'd1, 3'd0, 8'h40, 16'h2000, 16'h0456, 0, 1'b0);
    for (int fi = 0; fi < 2; fi++)
      for (int c = 0; c < 8; c++)
        run_op(2'd1, 3'(c), fi ? 8'hC5 : 8'h00,
               16'h3000 + 16'(c * 2), 16'h0800 + 16'(c), 0, 1'b0);
    mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h22;
    run_op(2'd2, 3'd0, 8'h00, 16'hFFFF, 16'h0200, 0, 1'b0);
    run_op(2'd3, 3'd0, 8'h00, 16'h4000, 16'hFFFF, 0, 1'b0);
    mem[16'h5000] = 8'h34; mem[16'h5001] = 8'h12;
    run_op(2'd0, 3'd0, 8'h00, 16'h5000, 16'h0300, 3, 1'b1);

    waits = 0;
    aq.push_back(16'h6000);
    aq.push_back(16'h6001);
    @(negedge clk);
    op = 2'd0; sp_in = 16'h6000; ip_in = 16'h0700; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("pre_rst_addr", {16'd0, mem_addr}, 32'h6001);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_rd", {31'd0, mem_rd}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_outs", {done, taken, sp_we, ip_we, qq_we,
                       mem_addr, sp_out | ip_out | pop_data}, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("abort_nodone", sb.size(), 0);
    mem[16'h6000] = 8'h78; mem[16'h6001] = 8'h56;
    run_op(2'd0, 3'd0, 8'h00, 16'h6000, 16'h0700, 1, 1'b0);
    run_op(2'd2, 3'd0, 8'h00, 16'h6000, 16'h0701, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("aq_empty", aq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
